// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: issues PC addresses on a req/gnt/rvalid memory port and
// returns in-order {instr, addr} pairs to IF/ID, with credit-based hold and flush discard.
module ifetch_resp #(
   parameter int unsigned DEPTH = 2,
   parameter logic [31:0] NOP   = 32'h00000013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_addr_i,
   input  logic        fetch_en_i,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_addr_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic        hold_req_o
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   // out_q counts every granted request still awaiting rvalid, including those
   // marked for discard; disc_q is the subset to be dropped after a flush.
   logic [CW-1:0] out_q, out_d, disc_q, disc_d, rcnt_q, rcnt_d;
   logic [PW-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d, r_wr_q, r_wr_d, r_rd_q, r_rd_d;
   logic [31:0]   afifo_q [DEPTH];
   logic [31:0]   rdata_q [DEPTH];
   logic [31:0]   raddr_q [DEPTH];
   logic [31:0]   last_addr_q;

   logic          rsp, keep, pop, issue;
   logic [CW:0]   count;

   assign rsp   = mem_rvalid_i & (out_q != '0);
   assign keep  = rsp & (disc_q == '0) & ~flush_i;
   assign count = {1'b0, out_q} + {1'b0, rcnt_q};

   assign instr_valid_o = (rcnt_q != '0);
   assign pop           = instr_valid_o & instr_ready_i;
   assign instr_o       = instr_valid_o ? rdata_q[r_rd_q] : NOP;
   assign instr_addr_o  = instr_valid_o ? raddr_q[r_rd_q] : last_addr_q;

   // A same-cycle pop frees a credit, so a full responder still issues when drained.
   assign mem_req_o  = fetch_en_i & ~flush_i & ~rst_i & ((count < DEPTH_C) | pop);
   assign mem_addr_o = {pc_addr_i[31:2], 2'b00};
   assign issue      = mem_req_o & mem_gnt_i;
   assign hold_req_o = fetch_en_i & ~flush_i & ~rst_i & ~issue;

   always_comb begin
      out_d  = out_q + CW'(issue) - CW'(rsp);
      disc_d = disc_q;
      a_wr_d = a_wr_q + PW'(issue);
      a_rd_d = a_rd_q + PW'(keep);
      r_wr_d = r_wr_q + PW'(keep);
      r_rd_d = r_rd_q + PW'(pop);
      rcnt_d = rcnt_q + CW'(keep) - CW'(pop);
      if (rsp && disc_q != '0) disc_d = disc_q - CW'(1);
      if (flush_i) begin
         disc_d = out_d;
         a_wr_d = '0;
         a_rd_d = '0;
         r_wr_d = '0;
         r_rd_d = '0;
         rcnt_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q       <= '0;
         disc_q      <= '0;
         rcnt_q      <= '0;
         a_wr_q      <= '0;
         a_rd_q      <= '0;
         r_wr_q      <= '0;
         r_rd_q      <= '0;
         last_addr_q <= '0;
      end else begin
         out_q       <= out_d;
         disc_q      <= disc_d;
         rcnt_q      <= rcnt_d;
         a_wr_q      <= a_wr_d;
         a_rd_q      <= a_rd_d;
         r_wr_q      <= r_wr_d;
         r_rd_q      <= r_rd_d;
         last_addr_q <= instr_addr_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (issue) afifo_q[a_wr_q] <= mem_addr_o;
      if (keep) begin
         rdata_q[r_wr_q] <= mem_rdata_i;
         raddr_q[r_wr_q] <= afifo_q[a_rd_q];
      end
   end

   // A response with nothing outstanding means the memory was not reset with us.
   always_ff @(posedge clk_i)
      if (!rst_i) assert (!(mem_rvalid_i && out_q == '0));

endmodule

// File: tb/tb_ifetch_resp.sv
// Directed-vector bench for ifetch_resp: stream, grant stall, back-pressure,
// flush (with in-flight and colliding rvalid) and mid-stream reset.
module tb_ifetch_resp;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk_i, rst_i;
   logic [31:0] pc_addr_i;
   logic        fetch_en_i, flush_i;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] instr_o, instr_addr_o;
   logic        instr_valid_o, instr_ready_i, hold_req_o;

   int n_vec = 0;
   int n_err = 0;

   ifetch_resp #(.DEPTH(2), .NOP(NOP)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .pc_addr_i(pc_addr_i), .fetch_en_i(fetch_en_i),
      .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .instr_o(instr_o), .instr_addr_o(instr_addr_o), .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i), .hold_req_o(hold_req_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic drv(input logic en, input logic [31:0] pc, input logic gnt, input logic rv,
                      input logic [31:0] rd, input logic rdy, input logic fl);
      fetch_en_i    = en;
      pc_addr_i     = pc;
      mem_gnt_i     = gnt;
      mem_rvalid_i  = rv;
      mem_rdata_i   = rd;
      instr_ready_i = rdy;
      flush_i       = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_req(input string tag, input logic req, input logic hold);
      chk({tag, ".req"}, {31'd0, mem_req_o}, {31'd0, req});
      chk({tag, ".hold"}, {31'd0, hold_req_o}, {31'd0, hold});
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] adr);
      chk({tag, ".vld"}, {31'd0, instr_valid_o}, {31'd0, v});
      chk({tag, ".instr"}, instr_o, ins);
      chk({tag, ".iaddr"}, instr_addr_o, adr);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      chk_req("rst", 1'b0, 1'b0);
      chk_out("rst", 1'b0, NOP, 32'h0);
      rst_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      do_reset();

      // stream 0x0,0x4,0x8 with single-cycle memory
      drv(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_req("s0", 1'b1, 1'b0); chk("s0.maddr", mem_addr_o, 32'h0);
      chk_out("s0", 1'b0, NOP, 32'h0);
      tick();
      drv(1'b1, 32'h4, 1'b1, 1'b1, 32'hAAAA_0001, 1'b1, 1'b0);
      chk_req("s1", 1'b1, 1'b0); chk("s1.vld", {31'd0, instr_valid_o}, 32'd0);
      tick();
      drv(1'b1, 32'h8, 1'b1, 1'b1, 32'hBBBB_0002, 1'b1, 1'b0);
      chk_req("s2", 1'b1, 1'b0); chk_out("s2", 1'b1, 32'hAAAA_0001, 32'h0);
      tick();
      drv(1'b0, 32'hC, 1'b0, 1'b1, 32'hCCCC_0003, 1'b1, 1'b0);
      chk_req("s3", 1'b0, 1'b0); chk_out("s3", 1'b1, 32'hBBBB_0002, 32'h4);
      tick();
      drv(1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_out("s4", 1'b1, 32'hCCCC_0003, 32'h8);
      tick();
      chk_out("s5", 1'b0, NOP, 32'h8);

      // grant stall at 0x10 for three cycles
      for (int i = 0; i < 3; i++) begin
         drv(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         chk_req("g.stall", 1'b1, 1'b1); chk("g.maddr", mem_addr_o, 32'h10);
         tick();
      end
      drv(1'b1, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_req("g.go", 1'b1, 1'b0);
      tick();
      drv(1'b1, 32'h14, 1'b1, 1'b1, 32'hD000_0010, 1'b1, 1'b0);
      chk_req("g.14", 1'b1, 1'b0); chk("g.14.vld", {31'd0, instr_valid_o}, 32'd0);
      tick();
      drv(1'b0, 32'h18, 1'b0, 1'b1, 32'hD000_0014, 1'b1, 1'b0);
      chk_out("g.o0", 1'b1, 32'hD000_0010, 32'h10);
      tick();
      drv(1'b0, 32'h18, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_out("g.o1", 1'b1, 32'hD000_0014, 32'h14);
      tick();
      chk("g.end", {31'd0, instr_valid_o}, 32'd0);

      // back-pressure with ready low
      do_reset();
      drv(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_req("b0", 1'b1, 1'b0);
      tick();
      drv(1'b1, 32'h4, 1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
      chk_req("b1", 1'b1, 1'b0);
      tick();
      drv(1'b1, 32'h8, 1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
      chk_req("b2", 1'b0, 1'b1); chk_out("b2", 1'b1, 32'hAAAA_0001, 32'h0);
      tick();
      drv(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_req("b3", 1'b0, 1'b1);
      tick();
      drv(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_req("b4.pop", 1'b1, 1'b0); chk_out("b4", 1'b1, 32'hAAAA_0001, 32'h0);
      tick();
      drv(1'b0, 32'hC, 1'b0, 1'b1, 32'hCCCC_0003, 1'b1, 1'b0);
      chk_out("b5", 1'b1, 32'hBBBB_0002, 32'h4);
      tick();
      drv(1'b0, 32'hC, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_out("b6", 1'b1, 32'hCCCC_0003, 32'h8);
      tick();
      chk("b.end", {31'd0, instr_valid_o}, 32'd0);

      // flush with two requests in flight
      drv(1'b1, 32'h20, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      drv(1'b1, 32'h24, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_req("f.24", 1'b1, 1'b0);
      tick();
      drv(1'b1, 32'h28, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      chk_req("f.flush", 1'b0, 1'b0);
      tick();
      drv(1'b1, 32'h100, 1'b1, 1'b1, 32'hDEAD_0020, 1'b1, 1'b0);
      chk_req("f.f1", 1'b0, 1'b1); chk("f.f1.vld", {31'd0, instr_valid_o}, 32'd0);
      tick();
      drv(1'b1, 32'h100, 1'b1, 1'b1, 32'hDEAD_0024, 1'b1, 1'b0);
      chk_req("f.f2", 1'b1, 1'b0); chk("f.f2.vld", {31'd0, instr_valid_o}, 32'd0);
      tick();
      drv(1'b0, 32'h104, 1'b0, 1'b1, 32'h1234_0100, 1'b1, 1'b0);
      chk("f.f3.vld", {31'd0, instr_valid_o}, 32'd0);
      tick();
      drv(1'b0, 32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_out("f.out", 1'b1, 32'h1234_0100, 32'h100);
      tick();
      chk("f.end", {31'd0, instr_valid_o}, 32'd0);

      // flush colliding with the rvalid for 0x40
      drv(1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      drv(1'b1, 32'h44, 1'b1, 1'b1, 32'hBAD0_0040, 1'b1, 1'b1);
      chk_req("c.flush", 1'b0, 1'b0);
      tick();
      drv(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_req("c.200", 1'b1, 1'b0); chk("c.vld", {31'd0, instr_valid_o}, 32'd0);
      tick();
      drv(1'b0, 32'h204, 1'b0, 1'b1, 32'h5678_0200, 1'b1, 1'b0);
      chk("c.vld2", {31'd0, instr_valid_o}, 32'd0);
      tick();
      drv(1'b0, 32'h204, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_out("c.out", 1'b1, 32'h5678_0200, 32'h200);
      tick();
      chk("c.end", {31'd0, instr_valid_o}, 32'd0);

      // reset mid-stream with one queued and one in flight
      drv(1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 32'h84, 1'b1, 1'b1, 32'hAAAA_0080, 1'b0, 1'b0);
      tick();
      rst_i = 1'b1;
      drv(1'b1, 32'h88, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_req("r.inrst", 1'b0, 1'b0); chk_out("r.pre", 1'b1, 32'hAAAA_0080, 32'h80);
      tick();
      rst_i = 1'b0;
      drv(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_out("r.post", 1'b0, NOP, 32'h0); chk_req("r.post", 1'b1, 1'b0);
      tick();
      drv(1'b1, 32'h4, 1'b1, 1'b1, 32'hEEEE_0000, 1'b1, 1'b0);
      chk_req("r.4", 1'b1, 1'b0);
      tick();
      drv(1'b0, 32'h8, 1'b0, 1'b1, 32'hFFFF_0004, 1'b1, 1'b0);
      chk_out("r.o0", 1'b1, 32'hEEEE_0000, 32'h0);
      tick();
      drv(1'b0, 32'h8, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_out("r.o1", 1'b1, 32'hFFFF_0004, 32'h4);
      tick();
      chk_out("r.end", 1'b0, NOP, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ifetch_resp.md
# ifetch_resp

Instruction-fetch responder between the PC register and instruction memory. It accepts the fetch address driven by the PC each cycle and issues it on a request/grant/response memory port. It returns fetched words in order, with their addresses, to the IF/ID stage. It requests a PC hold whenever the current address cannot be issued, and discards in-flight and buffered fetches when a jump flushes the front end.

## Interface
- DEPTH, 2, maximum fetches in flight plus buffered (credit limit); power of two, ≥2
- NOP, 32'h00000013, value driven on instr_o when instr_valid_o is low
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- pc_addr_i  in  32  fetch address from PC register
- fetch_en_i  in  1  front end wants to fetch pc_addr_i this cycle
- flush_i  in  1  jump taken; discard all older fetches
- mem_req_o  out  1  memory request valid
- mem_addr_o  out  32  request address; {pc_addr_i[31:2], 2'b00}
- mem_gnt_i  in  1  request accepted this cycle (valid only with mem_req_o)
- mem_rvalid_i  in  1  read data valid; responses in request order
- mem_rdata_i  in  32  read data
- instr_o  out  32  fetched instruction
- instr_addr_o  out  32  address of instr_o
- instr_valid_o  out  1  instr_o/instr_addr_o valid
- instr_ready_i  in  1  IF/ID consumes head entry when high with instr_valid_o
- hold_req_o  out  1  PC must hold this cycle (address not issued)

## Operation
- Credits: count = inflight + queued. inflight is the number of granted requests with no rvalid yet. queued is the number of response-buffer entries. count never exceeds DEPTH.
- mem_req_o = fetch_en_i & !flush_i & !rst_i & (count < DEPTH, or an instr pop occurs this cycle). Combinational; mem_addr_o is a combinational copy of aligned pc_addr_i.
- Issue = mem_req_o & mem_gnt_i. The issued address is pushed into an address FIFO of DEPTH entries.
- hold_req_o = fetch_en_i & !flush_i & !issue. The PC advances only on issue, which keeps addresses gap-free.
- Response: mem_rvalid_i with discard_cnt == 0 pushes {mem_rdata_i, address-FIFO head} into the response buffer and pops the address FIFO.
- Response while discard_cnt > 0: the data is dropped, discard_cnt decrements, and the address FIFO is not touched.
- Output: the head of the response buffer drives instr_o/instr_addr_o, registered. An empty buffer gives instr_valid_o = 0, instr_o = NOP, instr_addr_o unchanged.
- Pop on instr_valid_o & instr_ready_i.
- Flush: all queued entries are cleared and the address FIFO is cleared. discard_cnt ← inflight, including an rvalid arriving in the flush cycle, which is itself dropped. No request is made in the flush cycle.
- Simultaneous push and pop: both take effect, and count is unchanged.
- Unexpected rvalid (inflight == 0 and discard_cnt == 0) is a protocol error. It is ignored, and an assertion fires in simulation.

## Timing
- Reset values: mem_req_o 0, hold_req_o 0, instr_valid_o 0, instr_o NOP, instr_addr_o 0, inflight/queued/discard_cnt 0, FIFOs empty.
- Reset asserted mid-operation discards everything. Responses to pre-reset requests arriving later are treated as unexpected, so the memory must be reset together with this block.
- Minimum latency: gnt in cycle N, rvalid in cycle N+1, instr_valid_o high in cycle N+2.
- Throughput: 1 instr/cycle with single-cycle memory and DEPTH ≥ 2.
- Flush in cycle F: instr_valid_o is 0 in F+1. The first request for the jump target is in F+1, or later if inflight is nonzero.
- Back-pressure: with instr_ready_i held low, exactly DEPTH requests issue. After that, hold_req_o stays high while fetch_en_i is high.

## Test plan
- Reset then stream: fetch_en_i=1, PC 0x0,0x4,0x8, gnt always, rvalid one cycle later with data A,B,C → instr_valid_o from cycle 2, (A,0x0),(B,0x4),(C,0x8) on consecutive cycles, hold_req_o never high.
- Grant stall: mem_gnt_i low for 3 cycles at PC 0x10 → hold_req_o high for those 3 cycles, mem_addr_o stays 0x10, single issue of 0x10, output addresses contiguous.
- Back-pressure: instr_ready_i=0 from start, DEPTH=2 → exactly two grants (0x0,0x4), then hold_req_o=1. Raising ready pops 0x0 and re-enables issue of 0x8 in the same cycle.
- Flush with 2 in flight: issue 0x20,0x24 with no rvalid yet, flush_i pulse, then PC=0x100 → both late rvalids dropped, first output is (data,0x100), instr_valid_o=0 in the cycle after the flush.
- Flush colliding with rvalid: rvalid for 0x40 arrives in the flush cycle → 0x40 is never output and discard_cnt ends at 0.
- Reset mid-stream: rst_i for one cycle with 1 queued entry and 1 in flight → all outputs at reset values the next cycle, and a normal stream from PC 0x0 is delivered afterwards.
